pll_lock_seq: RTL and testbench
===============================

# pll_lock_seq

Power-up and recovery sequencer for the system PLL in the SDRAM/VGA display design. It sits on the 50 MHz reference clock beside the PLL and holds the PLL in reset for a fixed time, then waits for a stable `extlock`. It raises `pll_ready`, which the downstream reset generators for the SDRAM and VGA clock domains use as their release condition. If lock never arrives after bounded retries, it parks the PLL in reset and flags a fault.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `pll_reset` is held high per attempt (≥2)
- `LOCK_STABLE`, 1024: consecutive cycles synchronized lock must stay high before ready (≥2)
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock per attempt (≥2)
- `RETRY_MAX`, 3: extra attempts after the first before fault (0–15)

Ports:
- `sys_clk`  in  1  50 MHz reference clock, the same net as the PLL `refclk`
- `sys_rst_n`  in  1  reset; one clock, synchronous, active-low
- `extlock`  in  1  PLL lock, asynchronous to `sys_clk`
- `relock_req`  in  1  single-cycle request to restart the sequence
- `pll_reset`  out  1  active-high PLL reset
- `pll_ready`  out  1  PLL locked and stable
- `fault`  out  1  retries exhausted, PLL parked in reset
- `lock_lost`  out  1  sticky: lock dropped while in RUN
- `state`  out  3  current state code, for debug

## Operation
- `extlock` passes through a 2-FF synchronizer and becomes `lock_s`. Only `lock_s` is used.
- States and codes: RST=0, WAIT=1, STABLE=2, RUN=3, FAULT=4. One shared counter `cnt` of width $clog2 of the largest count, and a retry counter `rty`.
- RST: `pll_reset`=1. `cnt` counts 0..RST_CYCLES-1, then the FSM moves to WAIT with `cnt`=0.
- WAIT: `pll_reset`=0.
  - If `lock_s`=1, move to STABLE with `cnt`=0.
  - Otherwise, when `cnt`=LOCK_TIMEOUT-1: if `rty`=RETRY_MAX, move to FAULT; else increment `rty` and move to RST with `cnt`=0.
- STABLE:
  - If `lock_s`=0, return to WAIT with `cnt`=0. This glitch does not consume a retry.
  - When `cnt`=LOCK_STABLE-1 with `lock_s`=1, move to RUN and clear `rty`.
- RUN: `pll_ready`=1. Behaviour on `lock_s`=0 is set by the macro; see Configuration.
- FAULT: `pll_reset`=1, `fault`=1, `pll_ready`=0. The FSM stays here until `relock_req` or reset.
- `relock_req`:
  - Acted on only in RUN or FAULT. It moves the FSM to RST and clears `cnt`, `rty`, `fault` and `lock_lost`.
  - Ignored in RST, WAIT and STABLE.
- Simultaneous events:
  - `relock_req` beats lock loss in RUN.
  - `sys_rst_n`=0 beats everything.

## Timing
- All outputs are registered and decoded from the next state, so they change on the same edge as `state`.
- Reset values, after the edge that samples `sys_rst_n`=0:
  - `state`=RST, `pll_reset`=1, `pll_ready`=0, `fault`=0, `lock_lost`=0.
  - `cnt`=0, `rty`=0, synchronizer FFs cleared.
- Reset mid-operation aborts any state immediately with the same values. The sequence restarts from RST with a full RST_CYCLES hold.
- `pll_reset` high time per attempt is exactly RST_CYCLES cycles.
- Lock-to-ready latency is LOCK_STABLE+2 edges, counted from the first edge that samples `extlock`=1 while in WAIT: 1 synchronizer edge, 1 WAIT→STABLE edge, then LOCK_STABLE edges.
- Worst case to fault is (RETRY_MAX+1)·(RST_CYCLES+LOCK_TIMEOUT) cycles after reset release.
- Lock-loss reaction in RUN is 2 edges after `extlock` falls: 1 synchronizer edge plus 1 FSM edge.

## Configuration
- `PLL_LOCK_WATCHDOG_EN` defined, in RUN with `lock_s`=0:
  - `lock_lost`←1.
  - FSM moves to RST with `rty`=0 and `cnt`=0, so `pll_ready` drops and the PLL is re-reset automatically.
- Not defined:
  - `lock_lost`←1 as a sticky flag only.
  - FSM stays in RUN and `pll_ready` stays 1. Recovery happens only via `relock_req` or reset.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, RETRY_MAX=2.
- Release reset, then raise `extlock` 3 cycles into WAIT and hold it → `pll_reset` high exactly 4 cycles. `pll_ready` rises 10 edges after the first sampling of `extlock`=1, with `state`=3.
- `extlock` held 0 → 3 `pll_reset` pulses of 4 cycles, each separated by 32 low cycles. Then `fault`=1, `pll_reset`=1, `state`=4 at cycle 108, after which the FSM stays put.
- Drop `extlock` for 1 cycle at STABLE count 5 → FSM returns to WAIT with no extra `pll_reset` pulse. `pll_ready` rises 10 edges after lock resumes.
- In RUN, drop `extlock`:
  - With the macro: `lock_lost`=1 and `pll_ready`=0 two edges later, then a 4-cycle `pll_reset` pulse, then ready again once lock holds.
  - Without the macro: `lock_lost`=1, `pll_ready` stays 1, `pll_reset` stays 0.
- `relock_req` pulse in FAULT → `fault`=0 and the FSM re-enters RST. A `relock_req` pulse in WAIT → no state or counter change.
- Assert `sys_rst_n`=0 for 1 cycle in STABLE → all outputs at reset values on the next edge, and a full 4-cycle `pll_reset` follows.

Source files
------------

// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL reset/lock sequencer on the reference clock.
// Optional macro PLL_LOCK_WATCHDOG_EN: lock loss in RUN re-runs the sequence.
module pll_lock_seq #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int RETRY_MAX    = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       extlock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       pll_ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [2:0] state
);

    localparam int MAXA = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int MAXC = (MAXA > LOCK_TIMEOUT) ? MAXA : LOCK_TIMEOUT;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]    RTY_LIMIT = 4'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    rty_q, rty_d;
    logic [1:0]    sync_q;
    logic          lock_s;
    logic          lost_q, lost_d;
    logic          pll_reset_q, pll_ready_q, fault_q;

    assign lock_s = sync_q[1];

    // Two-flop synchronizer bringing extlock into the sys_clk domain.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], extlock};
        end
    end

    // Next-state, shared counter, retry and sticky lock-loss logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rty_d   = rty_q;
        lost_d  = lost_q;
        unique case (state_q)
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d = '0;
                    if (rty_q == RTY_LIMIT) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_RST;
                        rty_d   = rty_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    rty_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (relock_req) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                    rty_d   = '0;
                    lost_d  = 1'b0;
                end else if (!lock_s) begin
                    lost_d = 1'b1;
`ifdef PLL_LOCK_WATCHDOG_EN
                    state_d = S_RST;
                    cnt_d   = '0;
                    rty_d   = '0;
`endif
                end
            end
            S_FAULT: begin
                if (relock_req) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                    rty_d   = '0;
                    lost_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_RST;
                cnt_d   = '0;
                rty_d   = '0;
            end
        endcase
    end

    // State, counters and outputs decoded from the next state.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= S_RST;
            cnt_q       <= '0;
            rty_q       <= '0;
            lost_q      <= 1'b0;
            pll_reset_q <= 1'b1;
            pll_ready_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rty_q       <= rty_d;
            lost_q      <= lost_d;
            pll_reset_q <= (state_d == S_RST) || (state_d == S_FAULT);
            pll_ready_q <= (state_d == S_RUN);
            fault_q     <= (state_d == S_FAULT);
        end
    end

    assign pll_reset = pll_reset_q;
    assign pll_ready = pll_ready_q;
    assign fault     = fault_q;
    assign lock_lost = lost_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb_pll_lock_seq: directed bench for pll_lock_seq.
// Small parameters: RST 4, STABLE 8, TIMEOUT 32, RETRY 2.
module tb_pll_lock_seq;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       extlock;
    logic       relock_req;
    logic       pll_reset;
    logic       pll_ready;
    logic       fault;
    logic       lock_lost;
    logic [2:0] state;

    int n_vec  = 0;
    int n_fail = 0;

    pll_lock_seq #(
        .RST_CYCLES  (4),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(32),
        .RETRY_MAX   (2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .extlock   (extlock),
        .relock_req(relock_req),
        .pll_reset (pll_reset),
        .pll_ready (pll_ready),
        .fault     (fault),
        .lock_lost (lock_lost),
        .state     (state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_st"}, int'(state), 0);
        check({tag, "_rst"}, int'(pll_reset), 1);
        check({tag, "_rdy"}, int'(pll_ready), 0);
        check({tag, "_flt"}, int'(fault), 0);
        check({tag, "_ll"}, int'(lock_lost), 0);
    endtask

    task automatic hold_count(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (pll_reset && n < 50);
    endtask

    task automatic ready_count(output int n, output int rst_seen);
        n = 0;
        rst_seen = 0;
        do begin
            step();
            n++;
            if (pll_reset) rst_seen = 1;
        end while (!pll_ready && n < 60);
    endtask

    int n, hi, lo, rs;

    initial begin
        sys_rst_n  = 1'b0;
        extlock    = 1'b0;
        relock_req = 1'b0;

        // power-up, lock 3 cycles into WAIT
        step();
        chk_reset_vals("por");
        sys_rst_n = 1'b1;
        hold_count(n);
        check("por_hold", n, 4);
        check("por_wait", int'(state), 1);
        step();
        step();
        extlock = 1'b1;
        step();
        ready_count(n, rs);
        check("lock_lat", n, 10);
        check("lock_st", int'(state), 3);

        // lock loss in RUN
        extlock = 1'b0;
        step();
        check("ll_e0_rdy", int'(pll_ready), 1);
        step();
        check("ll_e1_rdy", int'(pll_ready), 1);
        step();
        check("ll_e2_ll", int'(lock_lost), 1);
`ifdef PLL_LOCK_WATCHDOG_EN
        check("ll_e2_rdy", int'(pll_ready), 0);
        check("ll_e2_st", int'(state), 0);
        extlock = 1'b1;
        hold_count(n);
        check("ll_hold", n, 4);
        ready_count(n, rs);
        check("ll_rerdy", int'(pll_ready), 1);
`else
        check("ll_e2_rdy", int'(pll_ready), 1);
        check("ll_e2_rst", int'(pll_reset), 0);
        extlock = 1'b1;
        repeat (3) step();
        check("ll_stay", int'(state), 3);
        check("ll_sticky", int'(lock_lost), 1);
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        check("rl_run_st", int'(state), 0);
        check("rl_run_ll", int'(lock_lost), 0);
        check("rl_run_rst", int'(pll_reset), 1);
        ready_count(n, rs);
        check("rl_rerdy", int'(pll_ready), 1);
`endif

        // one-cycle lock glitch in STABLE
        sys_rst_n = 1'b0;
        extlock   = 1'b0;
        step();
        sys_rst_n = 1'b1;
        hold_count(n);
        extlock = 1'b1;
        repeat (6) step();
        check("gl_stable", int'(state), 2);
        extlock = 1'b0;
        step();
        extlock = 1'b1;
        step();
        step();
        check("gl_wait", int'(state), 1);
        check("gl_rst", int'(pll_reset), 0);
        ready_count(n, rs);
        check("gl_lat", n, 9);
        check("gl_norst", rs, 0);

        // timeout to fault; relock pulse in WAIT is ignored
        sys_rst_n = 1'b0;
        extlock   = 1'b0;
        step();
        sys_rst_n = 1'b1;
        n  = 0;
        hi = 0;
        lo = 0;
        while (!fault && n < 300) begin
            if (pll_reset) hi++;
            else lo++;
            if (n == 10) relock_req = 1'b1;
            step();
            n++;
            if (n == 11) begin
                relock_req = 1'b0;
                check("rl_wait_st", int'(state), 1);
            end
        end
        check("flt_cyc", n, 108);
        check("flt_hi", hi, 12);
        check("flt_lo", lo, 96);
        check("flt_st", int'(state), 4);
        check("flt_rst", int'(pll_reset), 1);
        check("flt_rdy", int'(pll_ready), 0);
        repeat (20) step();
        check("flt_park", int'(state), 4);
        check("flt_keep", int'(fault), 1);

        // relock out of FAULT
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        check("rl_flt_f", int'(fault), 0);
        check("rl_flt_st", int'(state), 0);
        check("rl_flt_rst", int'(pll_reset), 1);

        // reset asserted in STABLE
        hold_count(n);
        extlock = 1'b1;
        n = 0;
        while (state != 3'd2 && n < 20) begin
            step();
            n++;
        end
        check("rs_in_stb", int'(state), 2);
        sys_rst_n = 1'b0;
        step();
        chk_reset_vals("mid");
        sys_rst_n = 1'b1;
        hold_count(n);
        check("mid_hold", n, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
